// File: rtl/cam_refill_ctrl.sv
// Refill controller for a 16-entry CAM: arbitrates three miss requesters round-robin,
// dedups against entries already installed, picks a victim, and serves flushes between refills.
module cam_refill_ctrl #(
  parameter int DATA_SIZE = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           miss_req,
  input  logic [DATA_SIZE-1:0] miss_tag0,
  input  logic [DATA_SIZE-1:0] miss_tag1,
  input  logic [DATA_SIZE-1:0] miss_tag2,
  output logic [2:0]           miss_ack,
  output logic [3:0]           miss_idx,
  input  logic [15:0]          hit0,
  input  logic [15:0]          hit1,
  input  logic [15:0]          hit2,
  input  logic                 flush,
  output logic [15:0]          we,
  output logic [DATA_SIZE-1:0] wdata,
  output logic [15:0]          valid,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, CHECK, WRITE, ACK, FLUSH} state_e;

  state_e               state_q, state_d;
  logic [1:0]           rr_ptr_q, rr_ptr_d, grant_q, grant_d;
  logic [3:0]           repl_ptr_q, repl_ptr_d, idx_q, idx_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [DATA_SIZE-1:0] tag_q, tag_d, wdata_q, wdata_d;
  logic [15:0]          valid_q, valid_d, we_q, we_d;
  logic [2:0]           miss_ack_q, miss_ack_d;
  logic [3:0]           miss_idx_q, miss_idx_d;
  logic                 busy_q, busy_d;

  function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Round-robin pick: scan from rr_ptr upward, descending loop so the first match wins.
  logic [3:0]           req_ext;
  logic [1:0]           gnt;
  logic                 gnt_vld;
  logic [DATA_SIZE-1:0] gnt_tag;
  assign req_ext = {1'b0, miss_req};

  always_comb begin
    gnt     = rr_ptr_q;
    gnt_vld = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      if (req_ext[mod3_add(rr_ptr_q, 2'(k))]) begin
        gnt     = mod3_add(rr_ptr_q, 2'(k));
        gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    case (gnt)
      2'd0:    gnt_tag = miss_tag0;
      2'd1:    gnt_tag = miss_tag1;
      default: gnt_tag = miss_tag2;
    endcase
  end

  // Only hits on valid entries count; stale match lines from invalid entries are ignored.
  logic [15:0] hit_sel, qual;
  logic [3:0]  qual_idx, free_idx, victim;
  logic        all_valid;

  always_comb begin
    case (grant_q)
      2'd0:    hit_sel = hit0;
      2'd1:    hit_sel = hit1;
      default: hit_sel = hit2;
    endcase
  end

  assign qual      = hit_sel & valid_q;
  assign all_valid = &valid_q;

  always_comb begin
    qual_idx = 4'd0;
    free_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (qual[i])     qual_idx = i[3:0];
      if (!valid_q[i]) free_idx = i[3:0];
    end
  end

  assign victim = all_valid ? repl_ptr_q : free_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 2'd0;
      grant_q      <= 2'd0;
      repl_ptr_q   <= 4'd0;
      idx_q        <= 4'd0;
      flush_pend_q <= 1'b0;
      tag_q        <= '0;
      wdata_q      <= '0;
      valid_q      <= 16'd0;
      we_q         <= 16'd0;
      miss_ack_q   <= 3'd0;
      miss_idx_q   <= 4'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      repl_ptr_q   <= repl_ptr_d;
      idx_q        <= idx_d;
      flush_pend_q <= flush_pend_d;
      tag_q        <= tag_d;
      wdata_q      <= wdata_d;
      valid_q      <= valid_d;
      we_q         <= we_d;
      miss_ack_q   <= miss_ack_d;
      miss_idx_q   <= miss_idx_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (flush || flush_pend_q) state_d = FLUSH;
        else if (gnt_vld)          state_d = CHECK;
      end
      CHECK:   state_d = (|qual) ? ACK : WRITE;
      WRITE:   state_d = ACK;
      ACK:     state_d = IDLE;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so each one is computed here for the state being entered.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    repl_ptr_d   = repl_ptr_q;
    idx_d        = idx_q;
    tag_d        = tag_q;
    wdata_d      = wdata_q;
    valid_d      = valid_q;
    we_d         = 16'd0;
    miss_ack_d   = 3'd0;
    miss_idx_d   = 4'd0;
    busy_d       = (state_d != IDLE);
    flush_pend_d = flush_pend_q |
                   (flush & ((state_q == CHECK) | (state_q == WRITE) | (state_q == ACK)));
    case (state_q)
      IDLE: begin
        if (!(flush || flush_pend_q) && gnt_vld) begin
          grant_d  = gnt;
          tag_d    = gnt_tag;
          rr_ptr_d = mod3_add(gnt, 2'd1);
        end
      end
      CHECK: begin
        if (|qual) begin
          idx_d      = qual_idx;
          miss_ack_d = 3'b001 << grant_q;
          miss_idx_d = qual_idx;
        end else begin
          idx_d           = victim;
          we_d            = 16'd1 << victim;
          wdata_d         = tag_q;
          valid_d[victim] = 1'b1;
          if (all_valid) repl_ptr_d = repl_ptr_q + 4'd1;
        end
      end
      WRITE: begin
        miss_ack_d = 3'b001 << grant_q;
        miss_idx_d = idx_q;
      end
      FLUSH: begin
        valid_d      = 16'd0;
        repl_ptr_d   = 4'd0;
        flush_pend_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign we       = we_q;
  assign wdata    = wdata_q;
  assign valid    = valid_q;
  assign miss_ack = miss_ack_q;
  assign miss_idx = miss_idx_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_cam_refill_ctrl.sv
// Scenario bench for cam_refill_ctrl: expected acks are queued when requests are raised
// and compared as each miss_ack appears.
module tb_cam_refill_ctrl;
  localparam int DS = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    miss_req;
  logic [DS-1:0] miss_tag0, miss_tag1, miss_tag2;
  logic [2:0]    miss_ack;
  logic [3:0]    miss_idx;
  logic [15:0]   hit0, hit1, hit2;
  logic          flush;
  logic [15:0]   we;
  logic [DS-1:0] wdata;
  logic [15:0]   valid;
  logic          busy;

  cam_refill_ctrl #(.DATA_SIZE(DS)) dut (
    .clk(clk), .rst(rst), .miss_req(miss_req),
    .miss_tag0(miss_tag0), .miss_tag1(miss_tag1), .miss_tag2(miss_tag2),
    .miss_ack(miss_ack), .miss_idx(miss_idx),
    .hit0(hit0), .hit1(hit1), .hit2(hit2), .flush(flush),
    .we(we), .wdata(wdata), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    g;
    logic [3:0]    idx;
    logic          wr;
    logic [DS-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  bit            ob_got;
  logic [2:0]    ob_ack;
  logic [3:0]    ob_idx;
  logic [15:0]   ob_we, ob_valid;
  logic [DS-1:0] ob_wdata;
  int            ob_lat;

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; miss_req = 3'b000; flush = 1'b0;
    hit0 = '0; hit1 = '0; hit2 = '0;
    miss_tag0 = '0; miss_tag1 = '0; miss_tag2 = '0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  // Watches the DUT until the next ack; latency counts from the last IDLE cycle seen.
  task automatic wait_ack(input int budget);
    int idle_c;
    ob_got = 1'b0; ob_ack = '0; ob_idx = '0; ob_we = '0; ob_wdata = '0;
    ob_valid = '0; ob_lat = -1;
    idle_c = busy ? -1 : cyc;
    for (int i = 0; i < budget && !ob_got; i++) begin
      tick();
      if (we != 16'd0) begin
        ob_we    = ob_we | we;
        ob_wdata = wdata;
      end
      if (miss_ack != 3'd0) begin
        ob_got   = 1'b1;
        ob_ack   = miss_ack;
        ob_idx   = miss_idx;
        ob_valid = valid;
        ob_lat   = cyc - idle_c;
        miss_req = miss_req & ~miss_ack;
        $display("txn ack=%b idx=%0d we=%h wdata=%h lat=%0d", ob_ack, ob_idx, ob_we, ob_wdata, ob_lat);
      end else if (!busy) begin
        idle_c = cyc;
        ob_we  = '0;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({we, wdata, miss_ack, miss_idx, busy, valid} !== '0) begin
      n_err++;
      $display("FAIL reset: we=%h wdata=%h ack=%b idx=%0d busy=%b valid=%h, want all zero",
               we, wdata, miss_ack, miss_idx, busy, valid);
    end
  endtask

  task automatic test_single();
    exp_t e; logic [2:0] xa; logic [15:0] xw; logic [DS-1:0] xd; int xl;
    do_reset();
    miss_tag0 = 19'h1ABCD;
    miss_req  = 3'b001;
    sb.push_back('{g: 2'd0, idx: 4'd0, wr: 1'b1, tag: 19'h1ABCD});
    wait_ack(10);
    e  = sb.pop_front();
    xa = 3'b001 << e.g;
    xw = e.wr ? (16'd1 << e.idx) : 16'd0;
    xd = e.wr ? e.tag : '0;
    xl = e.wr ? 3 : 2;
    n_vec++;
    if ({ob_got, ob_ack, ob_idx, ob_we, ob_wdata, ob_lat} !== {1'b1, xa, e.idx, xw, xd, xl}) begin
      n_err++;
      $display("FAIL single: ack=%b idx=%0d we=%h wdata=%h lat=%0d, want ack=%b idx=%0d we=%h wdata=%h lat=%0d",
               ob_ack, ob_idx, ob_we, ob_wdata, ob_lat, xa, e.idx, xw, xd, xl);
    end
    n_vec++;
    if (ob_valid !== 16'h0001) begin
      n_err++;
      $display("FAIL single_valid: valid=%h, want 0001", ob_valid);
    end
    tick();
    n_vec++;
    if ({busy, miss_ack, we} !== '0) begin
      n_err++;
      $display("FAIL single_idle: busy=%b ack=%b we=%h, want 0 0 0", busy, miss_ack, we);
    end
  endtask

  task automatic test_round_robin();
    exp_t e; logic [2:0] xa; logic [15:0] xw; logic [DS-1:0] xd; int xl;
    logic [1:0] ord [5];
    do_reset();
    // rounds 1/2: rr_ptr=0 -> 0,1,2; after lone grant to 1 -> 2,0,1
    ord[0] = 2'd0; ord[1] = 2'd1; ord[2] = 2'd2; ord[3] = 2'd0; ord[4] = 2'd1;
    for (int r = 0; r < 4; r++) begin
      miss_tag0 = 19'h00100 + 19'(r * 16);
      miss_tag1 = 19'h00200 + 19'(r * 16);
      miss_tag2 = 19'h00300 + 19'(r * 16);
      if (r == 2) begin
        miss_req = 3'b010;
        sb.push_back('{g: 2'd1, idx: 4'd6, wr: 1'b1, tag: miss_tag1});
      end else begin
        miss_req = 3'b111;
        for (int k = 0; k < 3; k++) begin
          logic [1:0] g;
          logic [DS-1:0] t;
          g = (r == 3) ? ord[k + 2] : ord[k];
          t = (g == 2'd0) ? miss_tag0 : (g == 2'd1) ? miss_tag1 : miss_tag2;
          sb.push_back('{g: g, idx: (r == 3) ? 4'(7 + k) : 4'(r * 3 + k), wr: 1'b1, tag: t});
        end
      end
      while (sb.size() != 0) begin
        wait_ack(12);
        e  = sb.pop_front();
        xa = 3'b001 << e.g;
        xw = e.wr ? (16'd1 << e.idx) : 16'd0;
        xd = e.wr ? e.tag : '0;
        xl = e.wr ? 3 : 2;
        n_vec++;
        if ({ob_got, ob_ack, ob_idx, ob_we, ob_wdata, ob_lat} !== {1'b1, xa, e.idx, xw, xd, xl}) begin
          n_err++;
          $display("FAIL round_robin r%0d: ack=%b idx=%0d we=%h wdata=%h lat=%0d, want ack=%b idx=%0d we=%h wdata=%h lat=%0d",
                   r, ob_ack, ob_idx, ob_we, ob_wdata, ob_lat, xa, e.idx, xw, xd, xl);
        end
      end
    end
  endtask

  // Entries 0..9 are valid on entry; rr_ptr points at requester 2.
  task automatic test_dedup();
    exp_t e; logic [2:0] xa; logic [15:0] xw; logic [DS-1:0] xd; int xl;
    for (int s = 0; s < 3; s++) begin
      hit0 = '0; hit1 = '0; hit2 = '0;
      case (s)
        0: begin
          hit2 = 16'h0020; miss_tag2 = 19'h11111; miss_req = 3'b100;
          sb.push_back('{g: 2'd2, idx: 4'd5, wr: 1'b0, tag: 19'h11111});
        end
        1: begin
          hit2 = 16'hC400; miss_tag2 = 19'h3F0F0; miss_req = 3'b100;
          sb.push_back('{g: 2'd2, idx: 4'd10, wr: 1'b1, tag: 19'h3F0F0});
        end
        default: begin
          hit1 = 16'h0028; miss_tag1 = 19'h22222; miss_req = 3'b010;
          sb.push_back('{g: 2'd1, idx: 4'd3, wr: 1'b0, tag: 19'h22222});
        end
      endcase
      wait_ack(10);
      e  = sb.pop_front();
      xa = 3'b001 << e.g;
      xw = e.wr ? (16'd1 << e.idx) : 16'd0;
      xd = e.wr ? e.tag : '0;
      xl = e.wr ? 3 : 2;
      n_vec++;
      if ({ob_got, ob_ack, ob_idx, ob_we, ob_wdata, ob_lat} !== {1'b1, xa, e.idx, xw, xd, xl}) begin
        n_err++;
        $display("FAIL dedup s%0d: ack=%b idx=%0d we=%h wdata=%h lat=%0d, want ack=%b idx=%0d we=%h wdata=%h lat=%0d",
                 s, ob_ack, ob_idx, ob_we, ob_wdata, ob_lat, xa, e.idx, xw, xd, xl);
      end
    end
    hit0 = '0; hit1 = '0; hit2 = '0;
  endtask

  // 16 fills, 15 replacements (repl_ptr -> 15), requester 1 takes entry 15, then wrap to 0.
  task automatic test_replace();
    exp_t e; logic [2:0] xa; logic [15:0] xw; logic [DS-1:0] xd; int xl;
    do_reset();
    for (int t = 0; t < 33; t++) begin
      logic [1:0] g;
      g = (t == 31) ? 2'd1 : 2'd0;
      miss_tag0 = 19'h10000 + 19'(t);
      miss_tag1 = 19'h20000 + 19'(t);
      sb.push_back('{g: g, idx: 4'(t % 16 + ((t >= 16 && t < 31) ? 0 : 0)), wr: 1'b1,
                     tag: (g == 2'd1) ? miss_tag1 : miss_tag0});
      if (t == 31) sb[0].idx = 4'd15;
      if (t == 32) sb[0].idx = 4'd0;
      miss_req = 3'b001 << g;
      wait_ack(10);
      e  = sb.pop_front();
      xa = 3'b001 << e.g;
      xw = e.wr ? (16'd1 << e.idx) : 16'd0;
      xd = e.wr ? e.tag : '0;
      xl = e.wr ? 3 : 2;
      n_vec++;
      if ({ob_got, ob_ack, ob_idx, ob_we, ob_wdata, ob_lat} !== {1'b1, xa, e.idx, xw, xd, xl}) begin
        n_err++;
        $display("FAIL replace t%0d: ack=%b idx=%0d we=%h wdata=%h lat=%0d, want ack=%b idx=%0d we=%h wdata=%h lat=%0d",
                 t, ob_ack, ob_idx, ob_we, ob_wdata, ob_lat, xa, e.idx, xw, xd, xl);
      end
    end
  endtask

  // All entries valid, repl_ptr=1: flush lands in WRITE, refill still acks, FLUSH follows.
  task automatic test_flush_write();
    exp_t e; logic [2:0] xa; logic [15:0] xw; logic [DS-1:0] xd; int xl;
    tick();
    miss_tag2 = 19'h2AAAA;
    miss_req  = 3'b100;
    tick();
    tick();
    n_vec++;
    if ({we, wdata} !== {16'h0002, 19'h2AAAA}) begin
      n_err++;
      $display("FAIL flush_write_we: we=%h wdata=%h, want 0002 2aaaa", we, wdata);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++;
    if ({miss_ack, miss_idx} !== {3'b100, 4'd1}) begin
      n_err++;
      $display("FAIL flush_write_ack: ack=%b idx=%0d, want 100 1", miss_ack, miss_idx);
    end
    miss_req = 3'b000;
    tick();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_write_idle: busy=%b, want 0", busy);
    end
    tick();
    n_vec++;
    if ({busy, we, miss_ack} !== {1'b1, 16'h0000, 3'b000}) begin
      n_err++;
      $display("FAIL flush_state: busy=%b we=%h ack=%b, want 1 0000 000", busy, we, miss_ack);
    end
    tick();
    n_vec++;
    if ({busy, valid} !== {1'b0, 16'h0000}) begin
      n_err++;
      $display("FAIL flush_clear: busy=%b valid=%h, want 0 0000", busy, valid);
    end
    // refill all 16, then one replacement must start from entry 0 again
    for (int t = 0; t < 17; t++) begin
      miss_tag0 = 19'h05000 + 19'(t);
      sb.push_back('{g: 2'd0, idx: 4'(t % 16), wr: 1'b1, tag: miss_tag0});
      miss_req = 3'b001;
      wait_ack(10);
      e  = sb.pop_front();
      xa = 3'b001 << e.g;
      xw = e.wr ? (16'd1 << e.idx) : 16'd0;
      xd = e.wr ? e.tag : '0;
      xl = e.wr ? 3 : 2;
      n_vec++;
      if ({ob_got, ob_ack, ob_idx, ob_we, ob_wdata, ob_lat} !== {1'b1, xa, e.idx, xw, xd, xl}) begin
        n_err++;
        $display("FAIL flush_refill t%0d: ack=%b idx=%0d we=%h wdata=%h lat=%0d, want ack=%b idx=%0d we=%h wdata=%h lat=%0d",
                 t, ob_ack, ob_idx, ob_we, ob_wdata, ob_lat, xa, e.idx, xw, xd, xl);
      end
    end
  endtask

  // Flush and a request in the same IDLE cycle: FLUSH goes first, then the refill.
  task automatic test_flush_idle();
    exp_t e; logic [2:0] xa; logic [15:0] xw; logic [DS-1:0] xd; int xl;
    tick();
    flush     = 1'b1;
    miss_tag0 = 19'h0BEEF;
    miss_req  = 3'b001;
    tick();
    flush = 1'b0;
    n_vec++;
    if ({busy, we, miss_ack} !== {1'b1, 16'h0000, 3'b000}) begin
      n_err++;
      $display("FAIL flush_idle_state: busy=%b we=%h ack=%b, want 1 0000 000", busy, we, miss_ack);
    end
    sb.push_back('{g: 2'd0, idx: 4'd0, wr: 1'b1, tag: 19'h0BEEF});
    wait_ack(10);
    e  = sb.pop_front();
    xa = 3'b001 << e.g;
    xw = e.wr ? (16'd1 << e.idx) : 16'd0;
    xd = e.wr ? e.tag : '0;
    xl = e.wr ? 3 : 2;
    n_vec++;
    if ({ob_got, ob_ack, ob_idx, ob_we, ob_wdata, ob_lat, ob_valid} !==
        {1'b1, xa, e.idx, xw, xd, xl, 16'h0001}) begin
      n_err++;
      $display("FAIL flush_idle: ack=%b idx=%0d we=%h wdata=%h lat=%0d valid=%h, want ack=%b idx=%0d we=%h wdata=%h lat=%0d valid=0001",
               ob_ack, ob_idx, ob_we, ob_wdata, ob_lat, ob_valid, xa, e.idx, xw, xd, xl);
    end
  endtask

  task automatic test_reset_midop();
    tick();
    miss_tag0 = 19'h0CAFE;
    miss_req  = 3'b001;
    tick();
    rst = 1'b1;
    tick();
    n_vec++;
    if ({we, wdata, miss_ack, miss_idx, busy, valid} !== '0) begin
      n_err++;
      $display("FAIL reset_midop: we=%h wdata=%h ack=%b idx=%0d busy=%b valid=%h, want all zero",
               we, wdata, miss_ack, miss_idx, busy, valid);
    end
    rst      = 1'b0;
    miss_req = 3'b000;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if ({we, miss_ack} !== '0) begin
        n_err++;
        $display("FAIL reset_quiet c%0d: we=%h ack=%b, want 0000 000", i, we, miss_ack);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_dedup();
    test_replace();
    test_flush_write();
    test_flush_idle();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cam_refill_ctrl.md
CAM_REFILL_CTRL -- requirements
Module: cam_refill_ctrl

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 19, the CAM tag/data width.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port miss_req, input, 3 bits: per-requester refill request; bit n is held high until the matching miss_ack bit.
REQ-005 SHALL have ports miss_tag0/1/2, input, DATA_SIZE bits each: tag to install for requester 0/1/2; held stable while the request is pending.
REQ-006 SHALL have port miss_ack, output, 3 bits: one-cycle completion pulse, one-hot, for the granted requester.
REQ-007 SHALL have port miss_idx, output, 4 bits: CAM entry holding the tag; valid only in the cycle miss_ack is nonzero.
REQ-008 SHALL have ports hit0/1/2, input, 16 bits each: raw CAM match vectors for requester 0/1/2.
REQ-009 SHALL have port flush, input, 1 bit: invalidate-all request, one-cycle pulse.
REQ-010 SHALL have port we, output, 16 bits: CAM per-entry write enable, one-hot or zero.
REQ-011 SHALL have port wdata, output, DATA_SIZE bits: CAM write data.
REQ-012 SHALL have port valid, output, 16 bits: per-entry valid bits.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, CHECK, WRITE, ACK and FLUSH; all outputs SHALL be registered.
REQ-015 In IDLE, flush or a pending flush SHALL take priority: go to FLUSH.
REQ-016 Otherwise in IDLE, if any miss_req bit is set, SHALL grant one bit round-robin: rr_ptr (0..2) names the first requester checked, and after a grant rr_ptr = granted+1 mod 3. The controller SHALL then latch the grant index and the matching miss_tag and go to CHECK.
REQ-017 In CHECK, if (hitG & valid) != 0 for granted G, SHALL skip the write and go to ACK with idx = lowest set bit of that vector (dedup of concurrent misses).
REQ-018 In CHECK with no qualified hit, SHALL select victim = lowest-index entry with valid=0; if all 16 are valid, victim = repl_ptr. The controller SHALL then go to WRITE.
REQ-019 In WRITE, we SHALL be one-hot at the victim for exactly one cycle. wdata SHALL equal the latched tag, and valid[victim] SHALL be set. If victim came from repl_ptr, repl_ptr SHALL increment, wrapping 15->0. The controller SHALL then go to ACK with idx = victim.
REQ-020 In ACK, miss_ack[G] SHALL be 1 and miss_idx SHALL equal idx for exactly one cycle; the next state SHALL be IDLE.
REQ-021 Latency SHALL be measured from the IDLE cycle that samples the request. A request that needs a write SHALL see its ack 3 cycles later. A dedup hit SHALL see its ack 2 cycles later.
REQ-022 FLUSH SHALL last one cycle: valid <= 0, repl_ptr <= 0, clear flush_pend, then return to IDLE. No we SHALL be asserted during FLUSH.
REQ-023 A flush arriving in CHECK, WRITE or ACK SHALL set flush_pend. The in-flight refill SHALL complete, including its ack, and the flush SHALL be served in the next IDLE cycle.
REQ-024 If a flush and a WRITE to the same entry coincide, the write SHALL complete and the later FLUSH SHALL clear valid.
REQ-025 we SHALL be 0 in every state except WRITE; miss_ack SHALL be 0 except in ACK.
REQ-026 A request dropped before its ack is a protocol violation; behaviour is undefined, and the FSM SHALL still return to IDLE within 3 cycles.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL enter IDLE and set valid=0, we=0, wdata=0, miss_ack=0, miss_idx=0, busy=0, rr_ptr=0, repl_ptr=0 and flush_pend=0.
REQ-028 rst asserted mid-operation SHALL abort the operation with no ack and no further we pulse.

Verification
REQ-029 Scenario: after reset, miss_req=001, tag0=0x1ABCD -> we=0x0001 with wdata=0x1ABCD 2 cycles later, then miss_ack=001 with miss_idx=0, and valid=0x0001.
REQ-030 Scenario: miss_req=111 held, all misses with distinct tags -> acks in order 0, 1, 2 and entries 0, 1, 2 filled. A second round with rr_ptr=0 SHALL again grant 0 first.
REQ-031 Scenario: valid=0xFFFF, repl_ptr=15, miss on requester 1 -> we=0x8000, repl_ptr wraps to 0, and the next miss writes entry 0.
REQ-032 Scenario: requester 2 misses, and in CHECK hit2=0x0020 with valid[5]=1 -> no we pulse, miss_ack=100 with miss_idx=5, 2 cycles after the request.
REQ-033 Scenario: flush during WRITE -> the ack still occurs, FLUSH follows the return to IDLE, valid=0, and repl_ptr=0.
REQ-034 Scenario: rst pulsed during CHECK -> no we pulse and no ack; all outputs match the REQ-027 reset values on the following cycle.
